// File: rtl/arima_pkg.sv
// Shared constants and control-mode encodings for the ARIMA filter blocks.
package arima_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 15;
  localparam int MAX_Q  = 10;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    LOAD  = 2'b10,
    CLEAR = 2'b11
  } ctrl_e;

  // Requested model order limited to the number of physical taps.
  function automatic int unsigned clamp_order(input logic [31:0] q_req, input int unsigned max_q);
    return (q_req > max_q) ? max_q : int'(q_req);
  endfunction

endpackage

// File: rtl/ma_inv_if.sv
// Sample-in / innovation-out streaming handshake of the MA inverter.
interface ma_inv_if #(
  parameter int DATA_W = arima_pkg::DATA_W
);
  logic signed [DATA_W-1:0] data_in;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid
  );
endinterface

// File: rtl/ma_inv_q15_mul.sv
// Fixed-point multiply: full-width signed product, arithmetic shift, wrap to DATA_W.
module q15_mul #(
  parameter int DATA_W = arima_pkg::DATA_W,
  parameter int FRAC_W = arima_pkg::FRAC_W
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_p
);
  logic signed [2*DATA_W-1:0] w_full;

  assign w_full = i_a * i_b;
  assign o_p    = DATA_W'(w_full >>> FRAC_W);
endmodule

// File: rtl/ma_inv.sv
// Moving-average model inverter: recovers e_t = x_t - sum c[k]*e_{t-1-k} with one
// shared multiplier stepping through the q taps, one sample in flight at a time.
module ma_inv #(
  parameter int DATA_W = arima_pkg::DATA_W,
  parameter int FRAC_W = arima_pkg::FRAC_W,
  parameter int MAX_Q  = arima_pkg::MAX_Q
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              control,
  input  logic [DATA_W*MAX_Q-1:0] coef_in,
  input  logic [31:0]             q_order_in,
  ma_inv_if.slave                 bus
);
  import arima_pkg::*;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  localparam int QW = $clog2(MAX_Q + 1);

  state_e                   r_state;
  state_e                   w_state_next;
  ctrl_e                    w_ctrl;
  logic signed [DATA_W-1:0] w_coef_in [MAX_Q];
  logic signed [DATA_W-1:0] w_shift_in [MAX_Q];
  logic signed [DATA_W-1:0] r_coef [MAX_Q];
  logic signed [DATA_W-1:0] r_hist [MAX_Q];
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] r_data_out;
  logic signed [DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_acc_sum;
  logic [QW-1:0]            r_q;
  logic [QW-1:0]            r_idx;
  logic                     w_clear;
  logic                     w_run;
  logic                     w_accept;
  logic                     w_load;
  logic                     w_mac_step;
  logic                     w_last;
  logic                     w_out_fire;

  assign w_ctrl     = ctrl_e'(control);
  assign w_clear    = rst || (w_ctrl == CLEAR);
  assign w_run      = (w_ctrl == RUN);
  assign w_accept   = (r_state == IDLE) && w_run && bus.in_valid;
  // A load request outside IDLE simply stalls until the FSM is back in IDLE.
  assign w_load     = (r_state == IDLE) && (w_ctrl == LOAD);
  assign w_mac_step = (r_state == MAC) && w_run;
  assign w_last     = (r_idx == r_q - QW'(1));
  assign w_out_fire = (r_state == OUT) && w_run && bus.out_ready;
  assign w_acc_sum  = r_acc + w_prod;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_Q; gi++) begin : g_tap
      assign w_coef_in[gi] = coef_in[gi*DATA_W +: DATA_W];
      if (gi == 0) begin : g_head
        assign w_shift_in[gi] = r_data_out;
      end else begin : g_body
        assign w_shift_in[gi] = r_hist[gi-1];
      end
    end
  endgenerate

  q15_mul #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .i_a (r_coef[r_idx]),
    .i_b (r_hist[r_idx]),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = (r_q == '0) ? OUT : MAC;
      MAC:     if (w_mac_step && w_last) w_state_next = OUT;
      OUT:     if (w_out_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = !rst && (r_state == IDLE) && w_run;
    bus.out_valid = (r_state == OUT);
    bus.data_out  = r_data_out;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_x        <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_q        <= '0;
      r_data_out <= '0;
    end else begin
      if (w_load) begin
        r_q <= QW'(clamp_order(q_order_in, MAX_Q));
      end
      if (w_accept) begin
        r_x   <= bus.data_in;
        r_acc <= '0;
        r_idx <= '0;
        if (r_q == '0) begin
          r_data_out <= bus.data_in;
        end
      end
      // idx parks on the last tap so the multiplier mux never leaves the array.
      if (w_mac_step) begin
        r_acc <= w_acc_sum;
        if (w_last) begin
          r_data_out <= r_x - w_acc_sum;
        end else begin
          r_idx <= r_idx + QW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_Q; k++) begin
      if (w_clear) begin
        r_coef[k] <= '0;
        r_hist[k] <= '0;
      end else begin
        if (w_load) begin
          r_coef[k] <= w_coef_in[k];
        end
        if (w_out_fire) begin
          r_hist[k] <= w_shift_in[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_inv.sv
// Self-checking bench for ma_inv: fixed vectors, corner sequences and random traffic
// against a direct sum-of-products model of the MA inversion.
`timescale 1ns/1ps
module tb_ma_inv;
  import arima_pkg::*;

  localparam int DW = 32;
  localparam int FW = 15;
  localparam int MQ = 10;

  typedef struct {
    bit                do_rst;
    int                q_in;
    logic signed [31:0] c0;
    logic signed [31:0] x;
    logic signed [31:0] exp_e;
    int                exp_lat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        control;
  logic [DW*MQ-1:0]  coef_in;
  logic [31:0]       q_order_in;

  ma_inv_if #(.DATA_W(DW)) bus ();

  ma_inv #(
    .DATA_W (DW),
    .FRAC_W (FW),
    .MAX_Q  (MQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .control    (control),
    .coef_in    (coef_in),
    .q_order_in (q_order_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 m_q;
  logic signed [31:0] m_c [MQ];
  logic signed [31:0] m_hist [$];
  logic signed [31:0] cfg_c [MQ];
  vec_t               vecs [7];
  logic signed [31:0] got_e;
  logic signed [31:0] exp_e;
  int                 got_lat;
  int                 lat;
  bit                 seen;

  // Reference: e = x - sum_k wrap32((c[k]*e_{t-1-k}) >>> 15), all sums wrapping at 32 bits.
  function automatic logic signed [31:0] model_e(input logic signed [31:0] x);
    logic signed [31:0] acc;
    longint             p;
    acc = 0;
    for (int k = 0; k < m_q; k++) begin
      p   = longint'(m_c[k]) * longint'(m_hist[k]);
      acc = acc + 32'(p >>> FW);
    end
    return x - acc;
  endfunction

  task automatic model_reset();
    m_q = 0;
    for (int k = 0; k < MQ; k++) m_c[k] = 0;
    m_hist.delete();
    repeat (MQ) m_hist.push_back(0);
  endtask

  task automatic model_push(input logic signed [31:0] e);
    m_hist.push_front(e);
    void'(m_hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    control = RUN;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic load_cfg(input int q_in);
    for (int k = 0; k < MQ; k++) coef_in[k*DW +: DW] = cfg_c[k];
    q_order_in = q_in;
    control = LOAD;
    tick();
    control = RUN;
    for (int k = 0; k < MQ; k++) m_c[k] = cfg_c[k];
    m_q = (q_in > MQ) ? MQ : q_in;
  endtask

  task automatic run_sample(input string name, input logic signed [31:0] x, input int hold,
                            input int stall_at, input int stall_len,
                            output logic signed [31:0] e_out, output int lat_out);
    logic signed [31:0] held;
    int                 it;
    bus.data_in = x;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check({name, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.data_in = $urandom();
    lat_out = 1;
    it = 0;
    while (!bus.out_valid && lat_out < 200) begin
      if (it == stall_at) begin
        control = STALL;
        bus.out_ready = 1'b1;
        repeat (stall_len) begin
          tick();
          lat_out++;
        end
        control = RUN;
        bus.out_ready = 1'b0;
      end else begin
        tick();
        lat_out++;
      end
      it++;
    end
    e_out = bus.data_out;
    check({name, "_valid"}, bus.out_valid, 1);
    held = bus.data_out;
    repeat (hold) begin
      tick();
      check({name, "_hold_valid"}, bus.out_valid, 1);
      check({name, "_hold_data"}, bus.data_out, held);
      check({name, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_drop"}, bus.out_valid, 0);
  endtask

  task automatic send(input string name, input logic signed [31:0] x, input int hold,
                      input int stall_at, input int stall_len);
    logic signed [31:0] req_e;
    logic signed [31:0] e_got;
    int                 req_lat;
    int                 lat_got;
    req_e   = model_e(x);
    req_lat = m_q + 1 + ((stall_at >= 0 && stall_at < m_q) ? stall_len : 0);
    run_sample(name, x, hold, stall_at, stall_len, e_got, lat_got);
    check({name, "_e"}, e_got, req_e);
    check({name, "_lat"}, lat_got, req_lat);
    model_push(req_e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 0,  0,      100,   100,   1};
    vecs[1] = '{1'b0, 1,  16384,  0,     -50,   2};
    vecs[2] = '{1'b1, 1,  16384,  32768, 32768, 2};
    vecs[3] = '{1'b0, 1,  16384,  32768, 16384, 2};
    vecs[4] = '{1'b0, 1,  16384,  0,     -8192, 2};
    vecs[5] = '{1'b0, 1,  -32768, 10,    -8182, 2};
    vecs[6] = '{1'b0, 15, 32768,  0,     8182,  11};

    // Reset behaviour, including in_ready held low while rst is high.
    rst = 1'b1;
    control = RUN;
    coef_in = '0;
    q_order_in = 0;
    bus.in_valid = 1'b1;
    bus.data_in = 5;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);
    control = STALL;
    #1;
    check("stall_in_ready", bus.in_ready, 0);
    control = LOAD;
    #1;
    check("load_in_ready", bus.in_ready, 0);
    control = RUN;
    #1;
    model_reset();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) do_reset();
      for (int k = 0; k < MQ; k++) cfg_c[k] = 0;
      cfg_c[0] = vecs[i].c0;
      load_cfg(vecs[i].q_in);
      run_sample($sformatf("vec%0d", i), vecs[i].x, 0, -1, 0, got_e, got_lat);
      check($sformatf("vec%0d_e", i), got_e, vecs[i].exp_e);
      check($sformatf("vec%0d_lat", i), got_lat, vecs[i].exp_lat);
      model_push(vecs[i].exp_e);
    end

    // Back-pressure in OUT: output frozen, history only advances on the handshake.
    do_reset();
    for (int k = 0; k < MQ; k++) cfg_c[k] = 0;
    cfg_c[0] = 16384;
    cfg_c[1] = -8192;
    load_cfg(2);
    send("bp_a", 1000, 0, -1, 0);
    send("bp_b", 2000, 5, -1, 0);
    send("bp_c", -300, 0, -1, 0);

    // Soft clear in the middle of MAC drops the sample and the configuration.
    for (int k = 0; k < MQ; k++) cfg_c[k] = 0;
    cfg_c[0] = 8192;
    cfg_c[1] = -4096;
    cfg_c[2] = 12000;
    load_cfg(3);
    send("clr_pre", 4000, 0, -1, 0);
    bus.data_in = 777;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    control = CLEAR;
    tick();
    control = RUN;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("clr_no_valid", seen, 0);
    model_reset();
    send("clr_after", 500, 0, -1, 0);

    // Order clamp to MAX_Q, then a 3-cycle stall inside MAC.
    do_reset();
    for (int k = 0; k < MQ; k++) cfg_c[k] = int'($urandom_range(0, 65535)) - 32768;
    load_cfg(15);
    send("clamp_a", 12345, 0, -1, 0);
    send("clamp_b", 54321, 0, -1, 0);
    send("clamp_stall", -777, 1, 2, 3);

    // Load request while in OUT is held off until the FSM is back in IDLE.
    do_reset();
    for (int k = 0; k < MQ; k++) cfg_c[k] = 0;
    cfg_c[0] = 16384;
    load_cfg(1);
    send("defer_pre", 2000, 0, -1, 0);
    exp_e = model_e(600);
    bus.data_in = 600;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("defer_lat", lat, 2);
    check("defer_e", bus.data_out, exp_e);
    coef_in[0 +: DW] = -16384;
    q_order_in = 2;
    control = LOAD;
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("defer_hold_valid", bus.out_valid, 1);
      check("defer_hold_data", bus.data_out, exp_e);
    end
    control = RUN;
    tick();
    bus.out_ready = 1'b0;
    check("defer_drop", bus.out_valid, 0);
    model_push(exp_e);
    send("defer_old_cfg", 300, 0, -1, 0);
    cfg_c[0] = -16384;
    load_cfg(2);
    send("defer_new_cfg", 300, 0, -1, 0);

    // Random configurations and traffic against the reference model.
    do_reset();
    for (int cfg = 0; cfg < 6; cfg++) begin
      for (int k = 0; k < MQ; k++) begin
        if (cfg % 3 == 2) cfg_c[k] = $urandom();
        else              cfg_c[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      load_cfg(int'($urandom_range(0, 12)));
      for (int s = 0; s < 8; s++) begin
        send($sformatf("rnd%0d_%0d", cfg, s), $urandom(), int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
             int'($urandom_range(1, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ma_inv.md
MA_INV -- requirements
Module: ma_inv

Interface
REQ-001 SHALL use a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 SHALL have these parameters:
- DATA_W, default 32, sample and coefficient width.
- FRAC_W, default 15, fractional bits.
- MAX_Q, default 10, tap count.
REQ-003 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- control  in  2  mode: 00 run, 01 stall, 10 load config, 11 soft clear.
- coef_in  in  DATA_W x MAX_Q  MA coefficients c[0..9], signed Q16.15.
- q_order_in  in  32  MA order q.
- data_in  in  DATA_W  observed sample x_t, signed.
- in_valid  in  1  data_in valid.
- in_ready  out  1  sample accepted when in_valid and in_ready are both high.
- data_out  out  DATA_W  recovered innovation e_t, signed.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.

Function
REQ-004 SHALL invert the MA model x_t = e_t + sum_{k=1..q} c[k-1]*e_{t-k}, producing e_t = x_t - sum_{k=1..q} c[k-1]*hist[k-1], where hist[0] is the most recently emitted e.
REQ-005 Product rule: 2*DATA_W-bit signed product, arithmetic shift right FRAC_W, keep the low DATA_W bits (wrap). The accumulator and the subtraction SHALL also wrap at DATA_W bits; there is no saturation.
REQ-006 FSM states SHALL be IDLE, MAC and OUT.
REQ-007 IDLE: in_ready = (control==00). On accept, latch x and clear acc and idx. Go to MAC if q>0; otherwise load data_out=x and go to OUT.
REQ-008 MAC: each cycle, acc += prod(c[idx], hist[idx]) and idx++. In the cycle where idx==q-1, data_out SHALL be registered as x-(acc+prod) and the FSM SHALL go to OUT.
REQ-009 OUT: out_valid=1. On out_ready, hist shifts (hist[0]<=e, hist[i]<=hist[i-1]), out_valid drops, and the FSM returns to IDLE.
REQ-010 out_valid SHALL rise exactly q+1 edges after the accepting edge when there is no stall; one sample is processed at a time, so the minimum period is q+2 cycles.
REQ-011 With out_valid high and out_ready low, data_out SHALL hold stable and hist SHALL NOT change.
REQ-012 control=01: FSM, acc, idx and hist SHALL freeze; in_ready=0; out_valid and data_out SHALL hold; out_ready SHALL be ignored.
REQ-013 control=10 in IDLE: c<=coef_in and q<=min(q_order_in, MAX_Q); in_ready=0. In MAC or OUT, control=10 SHALL behave as stall and the load SHALL be deferred.
REQ-014 control=11: identical effect to rst, in any state, with priority over the handshake.
REQ-015 q changes only via REQ-013; hist is preserved across a config load.

Reset
REQ-016 On rst or control=11, the following SHALL clear:
- FSM<=IDLE.
- out_valid<=0, data_out<=0.
- acc, idx, x<=0.
- hist[0..9]<=0, c[0..9]<=0, q<=0.
REQ-017 in_ready SHALL be 0 in every cycle in which rst is high.
REQ-018 A reset mid-MAC SHALL discard the sample in flight; no out_valid pulse SHALL follow.

Structure
REQ-019 Shared package arima_pkg SHALL hold DATA_W, FRAC_W, MAX_Q and the control-mode encodings (RUN, STALL, LOAD, CLEAR). The FSM state enum SHALL be local to ma_inv.
REQ-020 The multiply-shift-truncate SHALL be a combinational sub-module q15_mul, instanced once, with its inputs muxed by idx.

Verification
REQ-021 q=0, x=100 -> data_out=100 with out_valid one edge after accept, and hist[0]=100 after the output handshake.
REQ-022 q=1, c[0]=16384 (0.5), x sequence 32768, 32768, 0 with out_ready=1 -> e = 32768, 16384, -8192, each with out_valid 2 edges after accept.
REQ-023 q=2, out_ready held low 5 cycles in OUT -> data_out stable, in_ready=0, and the next e still uses the old hist.
REQ-024 control=11 asserted during MAC with q=3 -> no out_valid; the next sample x=500 -> e=500.
REQ-025 q_order_in=15 -> q=10 and latency 11 edges. A 3-cycle control=01 during MAC -> latency 14 and an unchanged result.
REQ-026 control=10 asserted while in OUT -> config unchanged until the handshake completes, then the load takes effect in IDLE.
